// File: rtl/rf_hazard_scoreboard.sv
// RAW hazard scoreboard for the OTTER register file: counts in-flight writes per
// architectural register and stalls decode until every source has committed.
module rf_hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SB_ISSUE_VALID,
    input  logic [4:0]  SB_RS1,
    input  logic [4:0]  SB_RS2,
    input  logic        SB_USE_RS1,
    input  logic        SB_USE_RS2,
    input  logic [4:0]  SB_RD,
    input  logic        SB_RD_WE,
    input  logic        SB_RETIRE_VALID,
    input  logic [4:0]  SB_RETIRE_RD,
    input  logic        SB_CLEAR,
    output logic        SB_STALL,
    output logic        SB_ISSUE_ACCEPT,
    output logic [31:0] SB_BUSY,
    output logic        SB_IDLE,
    output logic        SB_ERR
);

    localparam logic [1:0] CNT_MAX = MAX_INFLIGHT[1:0];

    logic [1:0]  cnt     [32];
    logic [1:0]  cnt_nxt [32];
    logic [31:0] busy_nxt;
    logic        err_set;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        rd_full;
    logic        inc_en;
    logic        dec_en;

    // Hazard terms look only at registered counts; a same-cycle retire must not
    // release the stall because the synchronous RF read would still see old data.
    assign rs1_pending     = SB_USE_RS1 && (cnt[SB_RS1] != 2'd0);
    assign rs2_pending     = SB_USE_RS2 && (cnt[SB_RS2] != 2'd0);
    assign rd_full         = SB_RD_WE && (SB_RD != 5'd0) && (cnt[SB_RD] == CNT_MAX);
    assign SB_STALL        = SB_ISSUE_VALID && (rs1_pending || rs2_pending || rd_full);
    assign SB_ISSUE_ACCEPT = SB_ISSUE_VALID && !SB_STALL;

    assign inc_en = SB_ISSUE_ACCEPT && SB_RD_WE && (SB_RD != 5'd0);
    assign dec_en = SB_RETIRE_VALID && (SB_RETIRE_RD != 5'd0);

    always_comb begin
        err_set    = 1'b0;
        cnt_nxt[0] = 2'd0;
        for (int i = 1; i < 32; i++) begin
            cnt_nxt[i] = cnt[i];
            if (SB_CLEAR) begin
                cnt_nxt[i] = 2'd0;
            end else if (inc_en && (SB_RD == 5'(i)) && dec_en && (SB_RETIRE_RD == 5'(i))) begin
                cnt_nxt[i] = cnt[i];
            end else if (inc_en && (SB_RD == 5'(i))) begin
                if (cnt[i] == CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 2'd1;
                end
            end else if (dec_en && (SB_RETIRE_RD == 5'(i))) begin
                if (cnt[i] == 2'd0) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        busy_nxt = '0;
        for (int i = 1; i < 32; i++) begin
            busy_nxt[i] = (cnt_nxt[i] != 2'd0);
        end
    end

    // Status flags are registered from next-state counts so they track cnt exactly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '{default: 2'd0};
            SB_BUSY <= '0;
            SB_IDLE <= 1'b1;
            SB_ERR  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            SB_BUSY <= busy_nxt;
            SB_IDLE <= (busy_nxt == 32'd0);
            SB_ERR  <= SB_ERR || err_set;
        end
    end

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// Table-driven bench for rf_hazard_scoreboard with a queue holding the expected
// post-edge status of each applied vector.
module tb_rf_hazard_scoreboard;

    logic        CLK;
    logic        RST_N;
    logic        SB_ISSUE_VALID;
    logic [4:0]  SB_RS1;
    logic [4:0]  SB_RS2;
    logic        SB_USE_RS1;
    logic        SB_USE_RS2;
    logic [4:0]  SB_RD;
    logic        SB_RD_WE;
    logic        SB_RETIRE_VALID;
    logic [4:0]  SB_RETIRE_RD;
    logic        SB_CLEAR;
    logic        SB_STALL;
    logic        SB_ISSUE_ACCEPT;
    logic [31:0] SB_BUSY;
    logic        SB_IDLE;
    logic        SB_ERR;

    rf_hazard_scoreboard #(.MAX_INFLIGHT(3)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .SB_ISSUE_VALID(SB_ISSUE_VALID), .SB_RS1(SB_RS1), .SB_RS2(SB_RS2),
        .SB_USE_RS1(SB_USE_RS1), .SB_USE_RS2(SB_USE_RS2),
        .SB_RD(SB_RD), .SB_RD_WE(SB_RD_WE),
        .SB_RETIRE_VALID(SB_RETIRE_VALID), .SB_RETIRE_RD(SB_RETIRE_RD),
        .SB_CLEAR(SB_CLEAR), .SB_STALL(SB_STALL), .SB_ISSUE_ACCEPT(SB_ISSUE_ACCEPT),
        .SB_BUSY(SB_BUSY), .SB_IDLE(SB_IDLE), .SB_ERR(SB_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        rv;
        logic [4:0]  rrd;
        logic        clr;
        logic        stall;
        logic        acc;
        logic [31:0] busy;
        logic        idle;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic iv, input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic we,
        input logic rv, input logic [4:0] rrd, input logic clr,
        input logic stall, input logic acc, input logic [31:0] busy,
        input logic idle, input logic err);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.we = we; v.rv = rv; v.rrd = rrd; v.clr = clr;
        v.stall = stall; v.acc = acc; v.busy = busy; v.idle = idle; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        SB_ISSUE_VALID  = v.iv;
        SB_RS1          = v.rs1;
        SB_USE_RS1      = v.u1;
        SB_RS2          = v.rs2;
        SB_USE_RS2      = v.u2;
        SB_RD           = v.rd;
        SB_RD_WE        = v.we;
        SB_RETIRE_VALID = v.rv;
        SB_RETIRE_RD    = v.rrd;
        SB_CLEAR        = v.clr;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        RST_N = 1'b0;
        idle_inputs();

        //      iv rs1 u1 rs2 u2 rd we rv rrd clr  stall acc busy         idle err
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 0, 32'h0000_0020, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 5, 0,  1, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  1, 0, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h0000_0080, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 1, 32'h0000_0200, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 9, 0,  0, 1, 32'h0000_0200, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 1, 32'h0000_0008, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 1, 32'h0000_0018, 0, 1));
        tbl.push_back(mk(1, 0, 0, 4, 0, 3, 1, 0, 0, 1,  0, 1, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(1, 4, 0, 4, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 1, 32'h0000_0400, 0, 1));
        tbl.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0400, 0, 1));
        tbl.push_back(mk(0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0400, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 1));

        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", SB_BUSY, 32'h0);
        check("reset_idle", 32'(SB_IDLE), 32'd1);
        check("reset_err", 32'(SB_ERR), 32'd0);
        check("reset_stall", 32'(SB_STALL), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge CLK);
            check($sformatf("v%0d_stall", i), 32'(SB_STALL), 32'(tbl[i].stall));
            check($sformatf("v%0d_accept", i), 32'(SB_ISSUE_ACCEPT), 32'(tbl[i].acc));
            sb_q.push_back(tbl[i]);
            @(posedge CLK);
            #1;
            e = sb_q.pop_front();
            check($sformatf("v%0d_busy", i), SB_BUSY, e.busy);
            check($sformatf("v%0d_idle", i), 32'(SB_IDLE), 32'(e.idle));
            check($sformatf("v%0d_err", i), 32'(SB_ERR), 32'(e.err));
        end

        // Reset mid-operation with a pending write to x20 and ERR set.
        drive(mk(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 1, 32'h0010_0000, 0, 1));
        @(posedge CLK);
        #1;
        idle_inputs();
        check("pend20_busy", SB_BUSY, 32'h0010_0000);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_busy", SB_BUSY, 32'h0);
        check("async_rst_idle", 32'(SB_IDLE), 32'd1);
        check("async_rst_err", 32'(SB_ERR), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(mk(1, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0));
        #1;
        check("post_rst_stall", 32'(SB_STALL), 32'd0);
        check("post_rst_accept", 32'(SB_ISSUE_ACCEPT), 32'd1);
        @(posedge CLK);
        #1;
        idle_inputs();
        check("post_rst_idle", 32'(SB_IDLE), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
